// File: rtl/prf_multiport.sv
// Multiported physical register file: data and ready arrays with write bypass,
// allocate-clears-ready, hardwired p0 and a registered same-address write conflict flag.
module prf_multiport #(
   parameter int NUM_PREGS = 64,
   parameter int DATA_W    = 32,
   parameter int NUM_RD    = 6,
   parameter int NUM_WR    = 3,
   parameter int NUM_AL    = 3,
   localparam int AW       = $clog2(NUM_PREGS)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_RD*AW-1:0]     rd_addr,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   output logic [NUM_RD-1:0]        rd_ready,
   input  logic [NUM_WR-1:0]        wr_en,
   input  logic [NUM_WR*AW-1:0]     wr_addr,
   input  logic [NUM_WR*DATA_W-1:0] wr_data,
   input  logic [NUM_AL-1:0]        al_en,
   input  logic [NUM_AL*AW-1:0]     al_addr,
   output logic                     wr_conflict
);

   logic [DATA_W-1:0]    data_q  [NUM_PREGS];
   logic [DATA_W-1:0]    data_d  [NUM_PREGS];
   logic [NUM_PREGS-1:0] ready_q;
   logic [NUM_PREGS-1:0] ready_d;
   logic                 conflict_q;
   logic                 conflict_d;

   logic [AW-1:0]        wa     [NUM_WR];
   logic [DATA_W-1:0]    wd     [NUM_WR];
   logic [NUM_WR-1:0]    wr_act;
   logic [AW-1:0]        aa     [NUM_AL];
   logic [NUM_AL-1:0]    al_act;

   // Writes/allocates to p0 and anything presented during reset are dropped here,
   // so neither the array update nor the bypass ever sees them.
   for (genvar w = 0; w < NUM_WR; w++) begin : g_wr
      assign wa[w]     = wr_addr[w*AW +: AW];
      assign wd[w]     = wr_data[w*DATA_W +: DATA_W];
      assign wr_act[w] = wr_en[w] && !reset && (wa[w] != '0);
   end

   for (genvar k = 0; k < NUM_AL; k++) begin : g_al
      assign aa[k]     = al_addr[k*AW +: AW];
      assign al_act[k] = al_en[k] && !reset && (aa[k] != '0);
   end

   // Ascending port order: later ports overwrite earlier ones, allocates apply last.
   always_comb begin
      data_d  = data_q;
      ready_d = ready_q;
      for (int w = 0; w < NUM_WR; w++) begin
         if (wr_act[w]) begin
            data_d[wa[w]]  = wd[w];
            ready_d[wa[w]] = 1'b1;
         end
      end
      for (int k = 0; k < NUM_AL; k++) begin
         if (al_act[k]) begin
            ready_d[aa[k]] = 1'b0;
         end
      end
   end

   always_comb begin
      conflict_d = 1'b0;
      for (int i = 0; i < NUM_WR; i++) begin
         for (int j = i + 1; j < NUM_WR; j++) begin
            if (wr_act[i] && wr_act[j] && (wa[i] == wa[j])) begin
               conflict_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int p = 0; p < NUM_PREGS; p++) begin
            data_q[p] <= '0;
         end
         ready_q    <= '1;
         conflict_q <= 1'b0;
      end else begin
         data_q     <= data_d;
         ready_q    <= ready_d;
         conflict_q <= conflict_d;
      end
   end

   assign wr_conflict = conflict_q;

   // Read ports: array value, overridden by the winning same-cycle write (allocates not bypassed).
   for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
      logic [AW-1:0]     ra;
      logic [DATA_W-1:0] rdat;
      logic              rrdy;

      assign ra = rd_addr[r*AW +: AW];

      always_comb begin
         rdat = data_q[ra];
         rrdy = ready_q[ra];
         for (int w = 0; w < NUM_WR; w++) begin
            if (wr_act[w] && (wa[w] == ra)) begin
               rdat = wd[w];
               rrdy = 1'b1;
            end
         end
         if (ra == '0) begin
            rdat = '0;
            rrdy = 1'b1;
         end
      end

      assign rd_data[r*DATA_W +: DATA_W] = rdat;
      assign rd_ready[r]                 = rrdy;
   end

`ifndef SYNTHESIS
   always_ff @(posedge clk) begin
      assert ((NUM_PREGS & (NUM_PREGS - 1)) == 0)
         else $error("prf_multiport: NUM_PREGS=%0d is not a power of two", NUM_PREGS);
      assert (reset || (data_q[0] == '0))
         else $error("prf_multiport: p0 data is nonzero (%h)", data_q[0]);
   end
`endif

endmodule

// File: tb/tb_prf_multiport.sv
// Directed and randomized bench for prf_multiport against an array-based reference model.
module tb_prf_multiport;

   localparam int NP = 64;
   localparam int DW = 32;
   localparam int NR = 6;
   localparam int NW = 3;
   localparam int NA = 3;
   localparam int AW = 6;

   logic              clk = 1'b0;
   logic              reset;
   logic [NR*AW-1:0]  rd_addr;
   logic [NR*DW-1:0]  rd_data;
   logic [NR-1:0]     rd_ready;
   logic [NW-1:0]     wr_en;
   logic [NW*AW-1:0]  wr_addr;
   logic [NW*DW-1:0]  wr_data;
   logic [NA-1:0]     al_en;
   logic [NA*AW-1:0]  al_addr;
   logic              wr_conflict;

   int nvec  = 0;
   int nfail = 0;

   // Reference model state
   logic [DW-1:0] mdata  [NP];
   logic          mready [NP];
   logic          mconf;

   prf_multiport #(
      .NUM_PREGS(NP), .DATA_W(DW), .NUM_RD(NR), .NUM_WR(NW), .NUM_AL(NA)
   ) dut (
      .clk(clk), .reset(reset),
      .rd_addr(rd_addr), .rd_data(rd_data), .rd_ready(rd_ready),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .al_en(al_en), .al_addr(al_addr),
      .wr_conflict(wr_conflict)
   );

   always #5 clk = ~clk;

   task automatic cmp(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      nvec++;
      assert (obs === exp)
         else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
         end
   endtask

   task automatic clear_inputs();
      wr_en = '0; wr_addr = '0; wr_data = '0;
      al_en = '0; al_addr = '0; rd_addr = '0;
   endtask

   task automatic set_wr(input int p, input int a, input logic [DW-1:0] d);
      wr_en[p] = 1'b1;
      wr_addr[p*AW +: AW] = a[AW-1:0];
      wr_data[p*DW +: DW] = d;
   endtask

   task automatic set_al(input int k, input int a);
      al_en[k] = 1'b1;
      al_addr[k*AW +: AW] = a[AW-1:0];
   endtask

   task automatic set_rd(input int r, input int a);
      rd_addr[r*AW +: AW] = a[AW-1:0];
   endtask

   function automatic logic [DW-1:0] rdd(input int r);
      return rd_data[r*DW +: DW];
   endfunction

   // Expected read value: stored value unless some enabled write this cycle names the
   // same register, in which case the highest-numbered such write is seen.
   task automatic check_model();
      int a;
      logic [DW-1:0] ed;
      logic er;
      if (reset) return;
      for (int r = 0; r < NR; r++) begin
         a  = int'(rd_addr[r*AW +: AW]);
         ed = mdata[a];
         er = mready[a];
         for (int w = 0; w < NW; w++) begin
            if (wr_en[w] && int'(wr_addr[w*AW +: AW]) == a) begin
               ed = wr_data[w*DW +: DW];
               er = 1'b1;
            end
         end
         if (a == 0) begin
            ed = '0;
            er = 1'b1;
         end
         cmp($sformatf("rd_data[%0d]@p%0d", r, a), rdd(r), ed);
         cmp($sformatf("rd_ready[%0d]@p%0d", r, a), {31'b0, rd_ready[r]}, {31'b0, er});
      end
      cmp("wr_conflict", {31'b0, wr_conflict}, {31'b0, mconf});
   endtask

   task automatic model_update();
      int cnt [NP];
      int a;
      if (reset) begin
         for (int p = 0; p < NP; p++) begin
            mdata[p]  = '0;
            mready[p] = 1'b1;
         end
         mconf = 1'b0;
         return;
      end
      for (int p = 0; p < NP; p++) cnt[p] = 0;
      for (int w = 0; w < NW; w++) begin
         a = int'(wr_addr[w*AW +: AW]);
         if (wr_en[w] && a != 0) begin
            mdata[a]  = wr_data[w*DW +: DW];
            mready[a] = 1'b1;
            cnt[a]++;
         end
      end
      for (int k = 0; k < NA; k++) begin
         a = int'(al_addr[k*AW +: AW]);
         if (al_en[k] && a != 0) mready[a] = 1'b0;
      end
      mconf = 1'b0;
      for (int p = 0; p < NP; p++) if (cnt[p] >= 2) mconf = 1'b1;
   endtask

   task automatic finish_cycle();
      model_update();
      @(posedge clk);
      #1;
   endtask

   task automatic cycle();
      @(negedge clk);
      check_model();
      finish_cycle();
   endtask

   initial begin
      reset = 1'b1;
      clear_inputs();
      for (int p = 0; p < NP; p++) begin
         mdata[p]  = 'x;
         mready[p] = 1'bx;
      end
      mconf = 1'b0;
      cycle();
      cycle();
      reset = 1'b0;

      // Post-reset state
      for (int r = 0; r < NR; r++) set_rd(r, r * 7 + 1);
      @(negedge clk);
      check_model();
      cmp("reset_data", rdd(3), 32'h0);
      cmp("reset_ready", {26'b0, rd_ready}, {26'b0, 6'h3F});
      cmp("reset_conflict", {31'b0, wr_conflict}, 32'h0);
      finish_cycle();

      // Write p5, read back on all ports next cycle
      clear_inputs();
      set_wr(0, 5, 32'hDEADBEEF);
      cycle();
      clear_inputs();
      for (int r = 0; r < NR; r++) set_rd(r, 5);
      @(negedge clk);
      check_model();
      for (int r = 0; r < NR; r++) begin
         cmp($sformatf("p5_data[%0d]", r), rdd(r), 32'hDEADBEEF);
      end
      cmp("p5_ready", {26'b0, rd_ready}, {26'b0, 6'h3F});
      finish_cycle();

      // Same-cycle bypass
      clear_inputs();
      set_wr(1, 9, 32'h1234);
      set_rd(0, 9);
      @(negedge clk);
      check_model();
      cmp("bypass_data", rdd(0), 32'h1234);
      cmp("bypass_ready", {31'b0, rd_ready[0]}, 32'h1);
      finish_cycle();

      // Two-port collision on p7
      clear_inputs();
      set_wr(0, 7, 32'hA);
      set_wr(2, 7, 32'hB);
      set_rd(0, 7);
      @(negedge clk);
      check_model();
      cmp("collide_bypass", rdd(0), 32'hB);
      finish_cycle();
      clear_inputs();
      set_rd(0, 7);
      @(negedge clk);
      check_model();
      cmp("collide_data", rdd(0), 32'hB);
      cmp("conflict_set", {31'b0, wr_conflict}, 32'h1);
      finish_cycle();
      @(negedge clk);
      check_model();
      cmp("conflict_clear", {31'b0, wr_conflict}, 32'h0);
      finish_cycle();

      // Allocate / write / allocate+write on p12
      clear_inputs();
      set_al(1, 12);
      set_rd(2, 12);
      @(negedge clk);
      check_model();
      cmp("alloc_no_bypass", {31'b0, rd_ready[2]}, 32'h1);
      finish_cycle();
      clear_inputs();
      set_rd(2, 12);
      @(negedge clk);
      check_model();
      cmp("alloc_ready0", {31'b0, rd_ready[2]}, 32'h0);
      finish_cycle();
      clear_inputs();
      set_wr(0, 12, 32'h55);
      cycle();
      clear_inputs();
      set_rd(2, 12);
      @(negedge clk);
      check_model();
      cmp("wr12_ready", {31'b0, rd_ready[2]}, 32'h1);
      cmp("wr12_data", rdd(2), 32'h55);
      finish_cycle();
      clear_inputs();
      set_wr(2, 12, 32'h66);
      set_al(0, 12);
      cycle();
      clear_inputs();
      set_rd(2, 12);
      @(negedge clk);
      check_model();
      cmp("alwr12_ready", {31'b0, rd_ready[2]}, 32'h0);
      cmp("alwr12_data", rdd(2), 32'h66);
      finish_cycle();

      // p0 is hardwired
      clear_inputs();
      for (int w = 0; w < NW; w++) set_wr(w, 0, 32'hFFFFFFFF);
      for (int k = 0; k < NA; k++) set_al(k, 0);
      set_rd(4, 0);
      @(negedge clk);
      check_model();
      cmp("p0_data_same", rdd(4), 32'h0);
      finish_cycle();
      clear_inputs();
      set_rd(4, 0);
      @(negedge clk);
      check_model();
      cmp("p0_data", rdd(4), 32'h0);
      cmp("p0_ready", {31'b0, rd_ready[4]}, 32'h1);
      cmp("p0_conflict", {31'b0, wr_conflict}, 32'h0);
      finish_cycle();

      // Fill every register, end with a colliding write, then reset with traffic pending
      for (int b = 1; b < NP; b += NW) begin
         clear_inputs();
         for (int w = 0; w < NW; w++) begin
            if (b + w < NP) set_wr(w, b + w, $urandom | 32'h1);
         end
         cycle();
      end
      clear_inputs();
      set_wr(0, 20, 32'h1111);
      set_wr(1, 20, 32'h2222);
      cycle();
      clear_inputs();
      reset = 1'b1;
      set_wr(0, 30, 32'hCAFE);
      set_wr(1, 31, 32'hBEEF);
      set_al(0, 32);
      cycle();
      reset = 1'b0;
      clear_inputs();
      for (int b = 0; b < NP; b += NR) begin
         for (int r = 0; r < NR; r++) set_rd(r, (b + r) % NP);
         @(negedge clk);
         check_model();
         for (int r = 0; r < NR; r++) begin
            cmp($sformatf("rst_data@p%0d", (b + r) % NP), rdd(r), 32'h0);
         end
         cmp($sformatf("rst_ready@%0d", b), {26'b0, rd_ready}, {26'b0, 6'h3F});
         cmp("rst_conflict", {31'b0, wr_conflict}, 32'h0);
         finish_cycle();
      end

      // Randomized traffic in a narrow address window to provoke collisions
      for (int n = 0; n < 600; n++) begin
         clear_inputs();
         reset = ($urandom_range(0, 79) == 0);
         for (int w = 0; w < NW; w++) begin
            if ($urandom_range(0, 2) != 0) set_wr(w, $urandom_range(0, 15), $urandom);
         end
         for (int k = 0; k < NA; k++) begin
            if ($urandom_range(0, 3) == 0) set_al(k, $urandom_range(0, 15));
         end
         for (int r = 0; r < NR; r++) set_rd(r, $urandom_range(0, 15));
         cycle();
      end
      reset = 1'b0;
      clear_inputs();
      cycle();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
